// File: rtl/ptd_share_pkg.sv
// ptd_share_pkg: shared types and constants for the time-multiplexed
// pair/triple (2-of-3 majority) detector scheduler.
//   state_e   : scheduler FSM states (IDLE, EVAL, RESP), 2 bits.
//   NREQ_MAX  : largest supported requester count.
//   CNT_W     : width of the optional ones counter (PTD_SHARE_CNT_EN).
//   sat_inc   : saturating increment for the ones counter.
package ptd_share_pkg;

    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EVAL = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/ptd_pair_triple_det.sv
// ptd_pair_triple_det: gate-level pair/triple detector.
// Output is 1 when at least two of the three inputs are 1.
//   in0, in1, in2 : detector inputs
//   out           : majority result
module ptd_pair_triple_det (
    input  logic in0,
    input  logic in1,
    input  logic in2,
    output logic out
);

    logic p01;
    logic p12;
    logic p02;

    and u_and01 (p01, in0, in1);
    and u_and12 (p12, in1, in2);
    and u_and02 (p02, in0, in2);
    or  u_or    (out, p01, p12, p02);

endmodule

// File: rtl/ptd_rr_arbiter.sv
// ptd_rr_arbiter: purely combinational round-robin arbiter.
// Searches req_val starting at ptr and wrapping modulo NREQ; the first set
// bit wins.
//   req_val : request vector
//   ptr     : highest-priority index for this search
//   gnt     : one-hot grant (all zero when no request)
//   gnt_id  : encoded grant index (0 when no request)
//   any_req : at least one request is set
module ptd_rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_val,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any_req
);

    always_comb begin
        int unsigned idx;
        logic [IDW-1:0] idx_w;
        idx     = 0;
        idx_w   = '0;
        gnt     = '0;
        gnt_id  = '0;
        any_req = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx   = (32'(ptr) + k) % NREQ;
            idx_w = IDW'(idx);
            if (!any_req && req_val[idx_w]) begin
                any_req    = 1'b1;
                gnt[idx_w] = 1'b1;
                gnt_id     = idx_w;
            end
        end
    end

endmodule

// File: rtl/ptd_share_sched.sv
// ptd_share_sched: time-multiplexes one pair/triple detector among NREQ
// requesters. A round-robin grant in IDLE latches the winner's triple, EVAL
// registers the detector output, RESP holds the tagged result until the
// consumer accepts it. One result per three cycles at best.
//
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   req_val / req_rdy   : per-requester handshake (req_rdy one-hot or zero)
//   req_bits            : triple i at [3i+2:3i], ordered {in2,in1,in0}
//   resp_val / resp_rdy : result handshake
//   resp_out, resp_id   : majority result and owning requester index
//   ones_cnt            : saturating count of accepted results equal to 1,
//                         present only when PTD_SHARE_CNT_EN is defined
module ptd_share_sched
    import ptd_share_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_val,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [3*NREQ-1:0] req_bits,
    output logic              resp_val,
    input  logic              resp_rdy,
    output logic              resp_out,
    output logic [IDW-1:0]    resp_id
`ifdef PTD_SHARE_CNT_EN
    ,
    output logic [CNT_W-1:0]  ones_cnt
`endif
);

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [2:0]     triple_q, triple_d;
    logic           resp_out_q, resp_out_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            any_req;
    logic [2:0]      sel_bits;
    logic            det_out;

    ptd_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_val (req_val),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .any_req (any_req)
    );

    // The single shared detector always looks at the registered triple.
    ptd_pair_triple_det u_det (
        .in0 (triple_q[0]),
        .in1 (triple_q[1]),
        .in2 (triple_q[2]),
        .out (det_out)
    );

    // One-hot mux of the granted requester's triple.
    always_comb begin
        sel_bits = 3'b000;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_bits = req_bits[3*i +: 3];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        triple_d   = triple_q;
        resp_out_d = resp_out_q;
        req_rdy    = '0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    req_rdy  = gnt;
                    triple_d = sel_bits;
                    id_d     = gnt_id;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                resp_out_d = det_out;
                state_d    = RESP;
            end
            RESP: begin
                if (resp_rdy) begin
                    state_d = IDLE;
                    // Priority moves to the requester just after the one served.
                    ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            triple_q   <= 3'b000;
            resp_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            triple_q   <= triple_d;
            resp_out_q <= resp_out_d;
        end
    end

    assign resp_val = (state_q == RESP);
    assign resp_out = resp_out_q;
    assign resp_id  = id_q;

`ifdef PTD_SHARE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (resp_val && resp_rdy && resp_out_q) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ones_cnt = cnt_q;
`else
    // No ones counter in this build.
`endif

endmodule

// File: tb/tb_ptd_share_sched.sv
// Self-checking bench for ptd_share_sched. Expected grants come from a
// modulo-NREQ search model, expected results from a population count, and
// expected timing from the IDLE/EVAL/RESP transaction shape.
module tb_ptd_share_sched;
    import ptd_share_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_val;
    logic [NREQ-1:0]   req_rdy;
    logic [3*NREQ-1:0] req_bits;
    logic              resp_val;
    logic              resp_rdy;
    logic              resp_out;
    logic [IDW-1:0]    resp_id;
`ifdef PTD_SHARE_CNT_EN
    logic [CNT_W-1:0]  ones_cnt;
    int                mcnt;
`endif

    int n_cmp;
    int n_bad;
    int mptr;
    int wait_cnt [NREQ];

    ptd_share_sched #(
        .NREQ (NREQ)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_bits (req_bits),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_out (resp_out),
        .resp_id  (resp_id)
`ifdef PTD_SHARE_CNT_EN
        ,
        .ones_cnt (ones_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic maj(input logic [2:0] t);
        return $countones(t) >= 2;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        req_val  = '0;
        resp_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mptr  = 0;
`ifdef PTD_SHARE_CNT_EN
        mcnt  = 0;
`endif
    endtask

    // Runs one full transaction starting from IDLE; caller guarantees a request.
    task automatic serve_one(input int hold, input bit rerand, output int g);
        logic [NREQ-1:0] exp_rdy;
        logic            exp_out;
        logic [IDW-1:0]  exp_id;
        #1;
        g = rr_pick(req_val, mptr);
        if (g < 0) begin
            $display("FAIL serve_setup: no request presented, req_val=%b", req_val);
            $fatal(1);
        end
        exp_rdy    = '0;
        exp_rdy[g] = 1'b1;
        exp_out    = maj(req_bits[3*g +: 3]);
        exp_id     = IDW'(g);
        n_cmp++;
        if (req_rdy !== exp_rdy) begin
            n_bad++;
            $display("FAIL grant: req_rdy=%b required %b (ptr=%0d)", req_rdy, exp_rdy, mptr);
        end
        n_cmp++;
        if (resp_val !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_resp_val: got %b required 0", resp_val);
        end
        @(posedge clk); #1;
        // Accepted triple may now change without affecting this result.
        if (rerand) req_bits[3*g +: 3] = 3'($urandom);
        n_cmp++;
        if (req_rdy !== '0 || resp_val !== 1'b0) begin
            n_bad++;
            $display("FAIL eval_outputs: req_rdy=%b resp_val=%b required 0/0", req_rdy, resp_val);
        end
        resp_rdy = (hold == 0);
        @(posedge clk); #1;
        n_cmp++;
        if (resp_val !== 1'b1 || resp_out !== exp_out || resp_id !== exp_id || req_rdy !== '0) begin
            n_bad++;
            $display("FAIL resp: val=%b out=%b id=%0d rdy=%b required 1/%b/%0d/0",
                     resp_val, resp_out, resp_id, req_rdy, exp_out, exp_id);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (resp_val !== 1'b1 || resp_out !== exp_out || resp_id !== exp_id ||
                req_rdy !== '0) begin
                n_bad++;
                $display("FAIL hold_stable: val=%b out=%b id=%0d rdy=%b required 1/%b/%0d/0",
                         resp_val, resp_out, resp_id, req_rdy, exp_out, exp_id);
            end
            if (h == hold - 1) resp_rdy = 1'b1;
        end
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        mptr     = (g + 1) % NREQ;
        n_cmp++;
        if (resp_val !== 1'b0) begin
            n_bad++;
            $display("FAIL after_handshake: resp_val=%b required 0", resp_val);
        end
`ifdef PTD_SHARE_CNT_EN
        if (exp_out && mcnt < 255) mcnt++;
        n_cmp++;
        if (ones_cnt !== 8'(mcnt)) begin
            n_bad++;
            $display("FAIL ones_cnt: got %0d required %0d", ones_cnt, mcnt);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req_val  = '0;
        req_bits = '0;
        resp_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        n_cmp++;
        if (resp_val !== 1'b0 || req_rdy !== '0 || resp_out !== 1'b0 || resp_id !== '0) begin
            n_bad++;
            $display("FAIL reset_values: val=%b rdy=%b out=%b id=%0d required 0/0/0/0",
                     resp_val, req_rdy, resp_out, resp_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mptr  = 0;
`ifdef PTD_SHARE_CNT_EN
        mcnt  = 0;
        n_cmp++;
        if (ones_cnt !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_ones_cnt: got %0d required 0", ones_cnt);
        end
`endif
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (resp_val !== 1'b0 || req_rdy !== '0) begin
                n_bad++;
                $display("FAIL idle_no_req: cycle %0d val=%b rdy=%b required 0/0",
                         c, resp_val, req_rdy);
            end
        end
    endtask

    task automatic test_single();
        int g;
        req_val       = 4'b0001;
        req_bits[2:0] = 3'b011;
        serve_one(0, 1'b0, g);
        req_bits[2:0] = 3'b010;
        serve_one(0, 1'b0, g);
        req_val = '0;
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        req_bits = {3'b111, 3'b110, 3'b101, 3'b000};
        req_val  = 4'b1111;
        for (int t = 0; t < 5; t++) serve_one(0, 1'b0, g);
        req_val = '0;
    endtask

    task automatic test_backpressure();
        int g;
        req_val        = 4'b0100;
        req_bits[8:6]  = 3'($urandom);
        serve_one(4, 1'b1, g);
        req_val = '0;
    endtask

    task automatic test_async_reset();
        int g;
        do_reset();
        req_val       = 4'b0010;
        req_bits[5:3] = 3'b110;
        serve_one(0, 1'b1, g);
        req_val       = 4'b0101;
        req_bits[2:0] = 3'b111;
        req_bits[8:6] = 3'b011;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (resp_val !== 1'b0 || resp_out !== 1'b0 || resp_id !== '0) begin
            n_bad++;
            $display("FAIL async_reset_outputs: val=%b out=%b id=%0d required 0/0/0",
                     resp_val, resp_out, resp_id);
        end
        // Back in IDLE with ptr=0: requester 0 is offered immediately.
        n_cmp++;
        if (req_rdy !== 4'b0001) begin
            n_bad++;
            $display("FAIL async_reset_idle: req_rdy=%b required 0001", req_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mptr  = 0;
`ifdef PTD_SHARE_CNT_EN
        mcnt  = 0;
`endif
        serve_one(0, 1'b1, g);
        serve_one(0, 1'b1, g);
        req_val = '0;
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < NREQ; i++) begin
            wait_cnt[i] = 0;
            req_bits[3*i +: 3] = 3'($urandom);
        end
        req_val = 4'($urandom);
        if (req_val == '0) req_val[$urandom_range(NREQ - 1)] = 1'b1;
        for (int t = 0; t < 60; t++) begin
            serve_one($urandom_range(3), 1'b1, g);
            n_cmp++;
            if (wait_cnt[g] > NREQ - 1) begin
                n_bad++;
                $display("FAIL fairness: requester %0d waited %0d grants, limit %0d",
                         g, wait_cnt[g], NREQ - 1);
            end
            wait_cnt[g] = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (i != g && req_val[i]) wait_cnt[i]++;
            end
            // Only the served requester and idle requesters may change inputs.
            for (int i = 0; i < NREQ; i++) begin
                if (i == g || !req_val[i]) begin
                    req_val[i]         = ($urandom_range(3) != 0);
                    req_bits[3*i +: 3] = 3'($urandom);
                    wait_cnt[i]        = 0;
                end
            end
            if (req_val == '0) req_val[$urandom_range(NREQ - 1)] = 1'b1;
        end
        req_val = '0;
    endtask

`ifdef PTD_SHARE_CNT_EN
    task automatic test_cnt_saturate();
        int g;
        do_reset();
        req_val       = 4'b0001;
        req_bits[2:0] = 3'b111;
        for (int t = 0; t < 300; t++) serve_one(0, 1'b0, g);
        req_bits[2:0] = 3'b000;
        for (int t = 0; t < 3; t++) serve_one(0, 1'b0, g);
        req_val = '0;
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mptr  = 0;
`ifdef PTD_SHARE_CNT_EN
        mcnt  = 0;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_async_reset();
        test_random();
`ifdef PTD_SHARE_CNT_EN
        test_cnt_saturate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
